led_div_seq: RTL and testbench

LED_DIV_SEQ -- requirements
Module: led_div_seq

---
 rtl/led_div_seq_pkg.sv | 30 +++
 rtl/led_div_seq_btn.sv | 67 ++++++
 rtl/led_div_seq.sv | 151 +++++++++++++++
 tb/tb_led_div_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_div_seq_pkg
// Purpose : Shared types and constants for the LED divider sequencer.
//           Holds the FSM state type, the divider width and its bounds,
//           and a counter-width helper.
// Ports   : none (package)
// Options : LED_DIV_SEQ_AUTO_EN (consumed by led_div_seq, not here)
// Revision: 1.0 - initial release
// ============================================================================
package led_div_seq_pkg;

  localparam int DIV_W = 5;
  localparam logic [DIV_W-1:0] DIV_MIN = 5'd0;
  localparam logic [DIV_W-1:0] DIV_MAX = 5'd31;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_div_seq_btn.sv
`default_nettype none
// ============================================================================
// Module  : led_btn_debounce
// Purpose : Two-flop synchronizer, debounce counter and one-cycle press
//           event for a single raw push button.
// Ports   : clk100  - clock
//           rst     - asynchronous active-low reset
//           i_btn   - raw asynchronous button level
//           o_level - debounced button level
//           o_press - one-cycle pulse on a debounced 0->1 transition,
//                     asserted in the same cycle o_level first reads 1
// Revision: 1.0 - initial release
// ============================================================================
module led_btn_debounce
  import led_div_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk100,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int              CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive cycles in which the synchronized level has
  // disagreed with the accepted level; the level flips on the cycle that
  // would make the count reach DEBOUNCE_CYCLES. Any agreement clears it.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == C_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : led_div_seq
// Purpose : Converts up/down push buttons (and an optional auto sweep) into
//           a 5-bit divider value plus a one-cycle write strobe for a
//           downstream LED counter.
// Ports   : clk100   - clock
//           rst      - asynchronous active-low reset
//           btn_up_i - raw button, increments divider (saturates at 31)
//           btn_dn_i - raw button, decrements divider (saturates at 0)
//           auto_i   - auto-sweep request (only with LED_DIV_SEQ_AUTO_EN)
//           div_o    - divider value
//           wren_o   - one-cycle write strobe, high when div_o is new
// Options : LED_DIV_SEQ_AUTO_EN - enables the auto-sweep timer; when
//           undefined, auto_i is ignored and no timer is built.
// Revision: 1.0 - initial release
// ============================================================================
module led_div_seq
  import led_div_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIV_RESET       = 20,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  input  logic             auto_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o
);

  localparam logic [DIV_W-1:0] C_DIV_RST = DIV_W'(DIV_RESET);

  logic w_lvl_up;
  logic w_lvl_dn;
  logic w_prs_up;
  logic w_prs_dn;
  logic w_up_evt;
  logic w_dn_evt;
  logic w_any_prs;
  logic w_auto_step;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_wren;

  led_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk100 (clk100),
    .rst    (rst),
    .i_btn  (btn_up_i),
    .o_level(w_lvl_up),
    .o_press(w_prs_up)
  );

  led_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_dn (
    .clk100 (clk100),
    .rst    (rst),
    .i_btn  (btn_dn_i),
    .o_level(w_lvl_dn),
    .o_press(w_prs_dn)
  );

  // Simultaneous up and down presses cancel each other.
  assign w_up_evt  = w_prs_up & ~w_prs_dn;
  assign w_dn_evt  = w_prs_dn & ~w_prs_up;
  assign w_any_prs = w_prs_up | w_prs_dn;

`ifdef LED_DIV_SEQ_AUTO_EN
  localparam int            AW     = cnt_width(AUTO_PERIOD);
  localparam logic [AW-1:0] C_AUTO = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] r_auto_cnt;

  // Counts only consecutive IDLE cycles with auto_i high. Any button press
  // (including a cancelled pair) restarts it, so a press always wins over
  // a coincident auto step.
  assign w_auto_step = auto_i && (r_state == ST_IDLE) && !w_any_prs &&
                       (r_auto_cnt == C_AUTO);

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_auto_cnt <= '0;
    end else if (!auto_i || (r_state != ST_IDLE) || w_any_prs || w_auto_step) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AW'(1);
    end
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = auto_i;
  assign w_auto_step   = 1'b0;
`endif

  // Sequencer: div_o is updated on the same edge that enters WRITE, so the
  // strobe and the new value appear together for exactly one cycle.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_div   <= C_DIV_RST;
      r_wren  <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_wren  <= 1'b1;
          r_state <= ST_WRITE;
        end
        ST_IDLE: begin
          if (w_up_evt) begin
            r_div   <= (r_div == DIV_MAX) ? DIV_MAX : r_div + DIV_W'(1);
            r_wren  <= 1'b1;
            r_state <= ST_WRITE;
          end else if (w_dn_evt) begin
            r_div   <= (r_div == DIV_MIN) ? DIV_MIN : r_div - DIV_W'(1);
            r_wren  <= 1'b1;
            r_state <= ST_WRITE;
          end else if (w_auto_step) begin
            // Auto sweep wraps 31 -> 0 by natural 5-bit overflow.
            r_div   <= r_div + DIV_W'(1);
            r_wren  <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Presses seen here are dropped; wait for both buttons released.
          if (!w_lvl_up && !w_lvl_dn) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign div_o  = r_div;
  assign wren_o = r_wren;

endmodule
`default_nettype wire

// File: tb/tb_led_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_div_seq
// Purpose : Self-checking bench for led_div_seq with DEBOUNCE_CYCLES=4 and
//           AUTO_PERIOD=8. A behavioural model predicts div_o/wren_o every
//           cycle; directed sequences add hand-computed expectations.
// Options : LED_DIV_SEQ_AUTO_EN - selects the auto-sweep scenario
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_div_seq;

  localparam int DB = 4;
  localparam int AP = 8;
  localparam int DR = 20;

  logic       clk100;
  logic       rst;
  logic       btn_up_i;
  logic       btn_dn_i;
  logic       auto_i;
  logic [4:0] div_o;
  logic       wren_o;

  int checks;
  int errors;
  int pulses;
  int cyc;

  led_div_seq #(
    .DEBOUNCE_CYCLES(DB),
    .DIV_RESET      (DR),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk100  (clk100),
    .rst     (rst),
    .btn_up_i(btn_up_i),
    .btn_dn_i(btn_dn_i),
    .auto_i  (auto_i),
    .div_o   (div_o),
    .wren_o  (wren_o)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: raw level delayed two cycles, accepted once it has disagreed
  // with the accepted level for DB cycles in a row. A press is the cycle
  // the accepted level first reads 1. Output side: after reset one write;
  // after any write the block is deaf until both buttons read released.
  logic [1:0] m_s1, m_s2, m_lvl, m_lvl_d;
  int         m_run [2];
  logic       m_init, m_wren, m_wait;
  int         m_div;
  int         m_auto_run;
  logic [1:0] m_press;
  logic       m_idle;
  logic       m_auto_step;

  assign m_press = m_lvl & ~m_lvl_d;
  assign m_idle  = !m_init && !m_wren && !m_wait;
`ifdef LED_DIV_SEQ_AUTO_EN
  assign m_auto_step = auto_i && (m_auto_run == AP - 1);
`else
  assign m_auto_step = 1'b0;
`endif

  always @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      m_s1       <= '0;
      m_s2       <= '0;
      m_lvl      <= '0;
      m_lvl_d    <= '0;
      m_run[0]   <= 0;
      m_run[1]   <= 0;
      m_init     <= 1'b1;
      m_wren     <= 1'b0;
      m_wait     <= 1'b0;
      m_div      <= DR;
      m_auto_run <= 0;
    end else begin
      m_s1    <= {btn_dn_i, btn_up_i};
      m_s2    <= m_s1;
      m_lvl_d <= m_lvl;
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          if (m_run[b] + 1 == DB) begin
            m_lvl[b] <= m_s2[b];
            m_run[b] <= 0;
          end else begin
            m_run[b] <= m_run[b] + 1;
          end
        end else begin
          m_run[b] <= 0;
        end
      end
      m_auto_run <= 0;
      if (m_init) begin
        m_init <= 1'b0;
        m_wren <= 1'b1;
      end else if (m_wren) begin
        m_wren <= 1'b0;
        m_wait <= 1'b1;
      end else if (m_wait) begin
        if (m_lvl == 2'b00) m_wait <= 1'b0;
      end else begin
        if (m_press == 2'b01) begin
          m_div  <= (m_div < 31) ? m_div + 1 : 31;
          m_wren <= 1'b1;
        end else if (m_press == 2'b10) begin
          m_div  <= (m_div > 0) ? m_div - 1 : 0;
          m_wren <= 1'b1;
        end else if (m_press == 2'b00 && m_auto_step) begin
          m_div  <= (m_div + 1) % 32;
          m_wren <= 1'b1;
        end else if (m_press == 2'b00 && auto_i) begin
          m_auto_run <= m_auto_run + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  always @(negedge clk100) begin
    if (rst === 1'b1) begin
      chk("model_div", int'(div_o), m_div);
      chk("model_wren", int'(wren_o), int'(m_wren));
    end
  end

  always @(negedge clk100) begin
    if (rst === 1'b1 && wren_o === 1'b1) pulses <= pulses + 1;
  end

  always @(posedge clk100) cyc <= cyc + 1;

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk100);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    auto_i   = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
  endtask

  task automatic press_up();
    btn_up_i = 1'b1;
    tick(10);
    btn_up_i = 1'b0;
    tick(10);
  endtask

  task automatic press_dn();
    btn_dn_i = 1'b1;
    tick(10);
    btn_dn_i = 1'b0;
    tick(10);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int p0;
  int seen;
  int np;
  int pv [3];
  int pt [3];

  initial begin
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    cyc      = 0;
    rst      = 1'b0;
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    auto_i   = 1'b0;
    tick(3);

    // Reset values, then the single write that loads DIV_RESET.
    chk("rst_div", int'(div_o), 20);
    chk("rst_wren", int'(wren_o), 0);
    rst = 1'b1;
    tick(1);
    chk("init_wren", int'(wren_o), 1);
    chk("init_div", int'(div_o), 20);
    tick(1);
    chk("init_wren_drop", int'(wren_o), 0);
    tick(10);
    chk("init_pulses", pulses, 1);

    // Clean up press: strobe exactly 7 edges after the raw rise.
    p0       = pulses;
    btn_up_i = 1'b1;
    tick(6);
    chk("up_early_wren", int'(wren_o), 0);
    chk("up_early_div", int'(div_o), 20);
    tick(1);
    chk("up_wren", int'(wren_o), 1);
    chk("up_div", int'(div_o), 21);
    tick(20);
    btn_up_i = 1'b0;
    tick(15);
    chk("up_single_pulse", pulses - p0, 1);

    // Bouncing down press from 20.
    do_reset();
    p0       = pulses;
    btn_dn_i = 1'b1;
    tick(3);
    btn_dn_i = 1'b0;
    tick(1);
    btn_dn_i = 1'b1;
    tick(20);
    chk("bounce_div", int'(div_o), 19);
    chk("bounce_pulses", pulses - p0, 1);
    btn_dn_i = 1'b0;
    tick(15);

    // Saturation at the top.
    do_reset();
    for (int i = 0; i < 11; i++) press_up();
    chk("reach_31", int'(div_o), 31);
    p0 = pulses;
    press_up();
    chk("sat_hi_div", int'(div_o), 31);
    chk("sat_hi_pulse", pulses - p0, 1);

    // Saturation at the bottom.
    for (int i = 0; i < 31; i++) press_dn();
    chk("reach_0", int'(div_o), 0);
    p0 = pulses;
    press_dn();
    chk("sat_lo_div", int'(div_o), 0);
    chk("sat_lo_pulse", pulses - p0, 1);

    // Coincident presses cancel.
    press_up();
    p0       = pulses;
    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    tick(20);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(15);
    chk("cancel_div", int'(div_o), 1);
    chk("cancel_pulses", pulses - p0, 0);

    // Reset asserted during WRITE takes effect immediately.
    btn_up_i = 1'b1;
    seen     = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick(1);
      if (wren_o === 1'b1) seen = 1;
    end
    chk("rstw_seen_write", seen, 1);
    rst = 1'b0;
    #1;
    chk("rstw_div", int'(div_o), 20);
    chk("rstw_wren", int'(wren_o), 0);
    btn_up_i = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(15);

`ifdef LED_DIV_SEQ_AUTO_EN
    // Auto sweep from 30: 31, 0, 1 spaced 10 cycles apart.
    do_reset();
    for (int i = 0; i < 10; i++) press_up();
    chk("auto_start", int'(div_o), 30);
    np     = 0;
    auto_i = 1'b1;
    for (int i = 0; i < 40 && np < 3; i++) begin
      tick(1);
      if (wren_o === 1'b1) begin
        pv[np] = int'(div_o);
        pt[np] = cyc;
        np++;
      end
    end
    auto_i = 1'b0;
    chk("auto_count", np, 3);
    if (np == 3) begin
      chk("auto_v0", pv[0], 31);
      chk("auto_v1", pv[1], 0);
      chk("auto_v2", pv[2], 1);
      chk("auto_gap1", pt[1] - pt[0], 10);
      chk("auto_gap2", pt[2] - pt[1], 10);
    end
    tick(5);
`else
    // auto_i has no effect in this build.
    p0     = pulses;
    auto_i = 1'b1;
    tick(40);
    auto_i = 1'b0;
    chk("auto_ignored_pulses", pulses - p0, 0);
    chk("auto_ignored_div", int'(div_o), 20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
